// File: rtl/csr_uart_pkg.sv
// Shared types, CSR addresses and status packing for the CSR-mapped UART.
package csr_uart_pkg;

    // CSR addresses of the responders that share the CSR bus.
    localparam logic [11:0] CSR_UART = 12'hbc0;
    localparam logic [11:0] CSR_LEDS = 12'hbc1;
    localparam logic [11:0] CSR_SIM  = 12'hbc2;

    // CSR modify codes; any other non-zero code is acknowledged and ignored.
    localparam logic [2:0] MOD_NONE  = 3'd0;
    localparam logic [2:0] MOD_WRITE = 3'd1;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_HIGH = 3'd4
    } rx_state_t;

    // ACC_DONE holds off a second valid until the requester drops sel.
    typedef enum logic {
        ACC_IDLE = 1'b0,
        ACC_DONE = 1'b1
    } acc_state_t;

    // Read word layout: {21'b0, overrun, tx_busy, rx_empty, rx_byte}.
    // The byte field is forced to zero while the buffer is empty.
    function automatic logic [31:0] pack_status(input logic       overrun,
                                                input logic       tx_busy,
                                                input logic       rx_full,
                                                input logic [7:0] rx_byte);
        pack_status = {21'd0, overrun, tx_busy, ~rx_full,
                       (rx_full ? rx_byte : 8'h00)};
    endfunction

endpackage

// File: rtl/csr_uart_if.sv
// CSR bus bundle between a requester (master) and a responder (slave).
interface csr_uart_if;
    logic        read;
    logic [2:0]  modify;
    logic [31:0] wdata;
    logic [11:0] addr;
    logic [31:0] rdata;
    logic        valid;

    modport master (output read, output modify, output wdata, output addr,
                    input  rdata, input  valid);
    modport slave  (input  read, input  modify, input  wdata, input  addr,
                    output rdata, output valid);
endinterface

// File: rtl/csr_uart_rx.sv
// UART receiver: input synchronizer, bit timer and 8N1 frame FSM.
// Emits a one-cycle rx_stb with rx_data for every frame with a valid stop bit.
module uart_rx
    import csr_uart_pkg::*;
#(
    parameter int DIV = 16
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx,
    output logic       rx_stb,
    output logic [7:0] rx_data
);

    localparam int               CNT_W       = $clog2(DIV);
    localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(DIV / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             rx_meta_r;
    logic             rx_sync_r;
    logic             rx_prev_r;
    rx_state_t        state_r, state_n;
    logic [CNT_W-1:0] cnt_r, cnt_n;
    logic [2:0]       bit_r, bit_n;
    logic [7:0]       shift_r, shift_n;
    logic             stb_r, stb_n;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // Frame FSM state, bit timer, shift register and strobe registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= RX_IDLE;
            cnt_r   <= CNT_ZERO;
            bit_r   <= 3'd0;
            shift_r <= 8'h00;
            stb_r   <= 1'b0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            bit_r   <= bit_n;
            shift_r <= shift_n;
            stb_r   <= stb_n;
        end
    end

    // Next-state logic: half-bit wait to the start-bit centre, then full bit periods.
    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        bit_n   = bit_r;
        shift_n = shift_r;
        stb_n   = 1'b0;
        case (state_r)
            RX_IDLE: begin
                if (rx_prev_r && !rx_sync_r) begin
                    state_n = RX_START;
                    cnt_n   = HALF_RELOAD;
                end else begin
                    state_n = RX_IDLE;
                end
            end
            RX_START: begin
                if (cnt_r != CNT_ZERO) begin
                    cnt_n = cnt_r - CNT_ONE;
                end else if (rx_sync_r) begin
                    // Line back high at mid start bit: a glitch, not a frame.
                    state_n = RX_IDLE;
                end else begin
                    state_n = RX_DATA;
                    cnt_n   = BIT_RELOAD;
                    bit_n   = 3'd0;
                end
            end
            RX_DATA: begin
                if (cnt_r != CNT_ZERO) begin
                    cnt_n = cnt_r - CNT_ONE;
                end else begin
                    shift_n = {rx_sync_r, shift_r[7:1]};
                    cnt_n   = BIT_RELOAD;
                    if (bit_r == 3'd7) begin
                        state_n = RX_STOP;
                    end else begin
                        bit_n = bit_r + 3'd1;
                    end
                end
            end
            RX_STOP: begin
                if (cnt_r != CNT_ZERO) begin
                    cnt_n = cnt_r - CNT_ONE;
                end else if (rx_sync_r) begin
                    stb_n   = 1'b1;
                    state_n = RX_IDLE;
                end else begin
                    // Framing error: drop the byte and resync on the idle level.
                    state_n = RX_WAIT_HIGH;
                end
            end
            RX_WAIT_HIGH: begin
                if (rx_sync_r) begin
                    state_n = RX_IDLE;
                end else begin
                    state_n = RX_WAIT_HIGH;
                end
            end
            default: begin
                state_n = RX_IDLE;
            end
        endcase
    end

    // The shift register holds the finished byte until the next frame's first data sample.
    assign rx_stb  = stb_r;
    assign rx_data = shift_r;

endmodule

// File: rtl/csr_uart.sv
// CSR-mapped UART responder: a write sends wdata[7:0] as an 8N1 frame on tx,
// a read returns the received byte with buffer and transmitter status.
// rdata is zero whenever valid is low so responders can be OR-combined.
module csr_uart
    import csr_uart_pkg::*;
#(
    parameter logic [11:0] CSR_ADDR   = CSR_UART,
    parameter int          CLOCK_RATE = 12000000,
    parameter int          BAUD_RATE  = 115200
) (
    input  logic       clk,
    input  logic       rstn,
    csr_uart_if.slave  bus,
    input  logic       rx,
    output logic       tx
);

    // Clocks per bit; the receiver needs at least 4 for its half-bit start check.
    localparam int               DIV        = CLOCK_RATE / BAUD_RATE;
    localparam int               CNT_W      = $clog2(DIV);
    localparam logic [CNT_W-1:0] BIT_RELOAD = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             sel_s;
    logic             wr_s;
    logic             tx_idle_s;
    logic             accept_s;
    logic             consume_s;
    logic             tx_start_s;
    logic [31:0]      status_s;
    logic             rx_stb_s;
    logic [7:0]       rx_data_s;
    logic             tx_level_s;
    logic             unused_s;

    acc_state_t       acc_state_r, acc_state_n;
    logic             valid_r;
    logic [31:0]      rdata_r;
    logic [7:0]       rx_buf_r;
    logic             rx_full_r;
    logic             ovr_r;
    tx_state_t        tx_state_r, tx_state_n;
    logic [CNT_W-1:0] tx_cnt_r, tx_cnt_n;
    logic [2:0]       tx_bit_r, tx_bit_n;
    logic [7:0]       tx_shift_r, tx_shift_n;
    logic             tx_r;

    uart_rx #(.DIV(DIV)) u_rx (
        .clk     (clk),
        .rstn    (rstn),
        .rx      (rx),
        .rx_stb  (rx_stb_s),
        .rx_data (rx_data_s)
    );

    // Access decode; a write must wait for an idle transmitter, anything else completes at once.
    assign sel_s      = (bus.read | (bus.modify != MOD_NONE)) & (bus.addr == CSR_ADDR);
    assign wr_s       = (bus.modify == MOD_WRITE);
    assign tx_idle_s  = (tx_state_r == TX_IDLE);
    assign accept_s   = sel_s & (acc_state_r == ACC_IDLE) & (~wr_s | tx_idle_s);
    assign consume_s  = accept_s & bus.read & rx_full_r;
    assign tx_start_s = accept_s & wr_s;
    assign status_s   = pack_status(ovr_r, ~tx_idle_s, rx_full_r, rx_buf_r);
    assign unused_s   = ^bus.wdata[31:8];

    // Access handshake state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_state_r <= ACC_IDLE;
        end else begin
            acc_state_r <= acc_state_n;
        end
    end

    // One valid per access: after accepting, wait for sel to drop before re-arming.
    always_comb begin
        acc_state_n = acc_state_r;
        case (acc_state_r)
            ACC_IDLE: begin
                if (accept_s) begin
                    acc_state_n = ACC_DONE;
                end else begin
                    acc_state_n = ACC_IDLE;
                end
            end
            ACC_DONE: begin
                if (!sel_s) begin
                    acc_state_n = ACC_IDLE;
                end else begin
                    acc_state_n = ACC_DONE;
                end
            end
            default: begin
                acc_state_n = ACC_IDLE;
            end
        endcase
    end

    // Registered response; rdata carries the status seen before this edge's updates.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_r <= 1'b0;
            rdata_r <= 32'h0000_0000;
        end else begin
            valid_r <= accept_s;
            rdata_r <= (accept_s & bus.read) ? status_s : 32'h0000_0000;
        end
    end

    // Single-byte receive buffer with overrun flag; a store wins over a same-cycle consume.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_buf_r  <= 8'h00;
            rx_full_r <= 1'b0;
            ovr_r     <= 1'b0;
        end else if (rx_stb_s) begin
            rx_buf_r  <= rx_data_s;
            rx_full_r <= 1'b1;
            ovr_r     <= rx_full_r & ~consume_s;
        end else if (consume_s) begin
            rx_full_r <= 1'b0;
            ovr_r     <= 1'b0;
        end else begin
            rx_full_r <= rx_full_r;
            ovr_r     <= ovr_r;
        end
    end

    // Transmit FSM, bit timer, shift register and line register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_state_r <= TX_IDLE;
            tx_cnt_r   <= CNT_ZERO;
            tx_bit_r   <= 3'd0;
            tx_shift_r <= 8'h00;
            tx_r       <= 1'b1;
        end else begin
            tx_state_r <= tx_state_n;
            tx_cnt_r   <= tx_cnt_n;
            tx_bit_r   <= tx_bit_n;
            tx_shift_r <= tx_shift_n;
            tx_r       <= tx_level_s;
        end
    end

    // Transmit sequencing: every state lasts DIV clocks, data goes out LSB first.
    always_comb begin
        tx_state_n = tx_state_r;
        tx_cnt_n   = tx_cnt_r;
        tx_bit_n   = tx_bit_r;
        tx_shift_n = tx_shift_r;
        case (tx_state_r)
            TX_IDLE: begin
                if (tx_start_s) begin
                    tx_state_n = TX_START;
                    tx_cnt_n   = BIT_RELOAD;
                    tx_bit_n   = 3'd0;
                    tx_shift_n = bus.wdata[7:0];
                end else begin
                    tx_state_n = TX_IDLE;
                end
            end
            TX_START: begin
                if (tx_cnt_r != CNT_ZERO) begin
                    tx_cnt_n = tx_cnt_r - CNT_ONE;
                end else begin
                    tx_state_n = TX_DATA;
                    tx_cnt_n   = BIT_RELOAD;
                    tx_bit_n   = 3'd0;
                end
            end
            TX_DATA: begin
                if (tx_cnt_r != CNT_ZERO) begin
                    tx_cnt_n = tx_cnt_r - CNT_ONE;
                end else begin
                    tx_cnt_n = BIT_RELOAD;
                    if (tx_bit_r == 3'd7) begin
                        tx_state_n = TX_STOP;
                    end else begin
                        tx_bit_n   = tx_bit_r + 3'd1;
                        tx_shift_n = {1'b0, tx_shift_r[7:1]};
                    end
                end
            end
            TX_STOP: begin
                if (tx_cnt_r != CNT_ZERO) begin
                    tx_cnt_n = tx_cnt_r - CNT_ONE;
                end else begin
                    tx_state_n = TX_IDLE;
                    tx_cnt_n   = BIT_RELOAD;
                end
            end
            default: begin
                tx_state_n = TX_IDLE;
            end
        endcase
    end

    // Line level for the state being entered, so the registered tx matches the state.
    always_comb begin
        tx_level_s = 1'b1;
        case (tx_state_n)
            TX_START: tx_level_s = 1'b0;
            TX_DATA:  tx_level_s = tx_shift_n[0];
            default:  tx_level_s = 1'b1;
        endcase
    end

    assign bus.valid = valid_r;
    assign bus.rdata = rdata_r;
    assign tx        = tx_r;

endmodule
